spi_master_arbiter: RTL and testbench
=====================================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters sharing one SPI master (2..8).
REQ-002 Parameter: LEN_W, 8, width of transaction byte count; length 0 means 2^LEN_W bytes.
REQ-003 Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester transaction request, level.
- reqLen  in  NUM_REQ*LEN_W  per-requester byte count, sampled at grant.
- cfgCpol  in  NUM_REQ  per-requester SPI polarity.
- cfgCpha  in  NUM_REQ  per-requester SPI phase.
- grant  out  NUM_REQ  one-hot owner of the master.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- txData  in  8  byte from the owner.
- txValid  in  1  owner byte valid.
- txReady  out  1  byte accepted this cycle.
- rxData  out  8  received byte to the owner.
- rxValid  out  1  rxData valid this cycle; the owner shall accept it, no backpressure.
- masterDataIn  out  8  to the master TX FIFO.
- masterWrite  out  1  master TX FIFO write strobe.
- masterRead  out  1  master RX FIFO read strobe.
- masterCpol  out  1  master polarity.
- masterCpha  out  1  master phase.
- masterDataOut  in  8  master RX FIFO head, first-word-fall-through.
- masterTxFull  in  1  master TX FIFO full.
- masterTxDataPresent  in  1  master TX busy.
- masterRxDataPresent  in  1  master RX FIFO non-empty.
- masterNcs  in  1  master chip select.
- nCsOut  out  NUM_REQ  per-device chip select.

Function
REQ-004 FSM states: IDLE, CONFIG, XFER, DRAIN, DONE.
REQ-005 IDLE: if masterRxDataPresent, pulse masterRead to discard the byte (flush); otherwise, if any req, grant the winner and go to CONFIG next cycle.
REQ-006 Arbitration is round-robin: search starts at index lastOwner+1 mod NUM_REQ; after reset lastOwner = NUM_REQ-1, so req[0] wins first.
REQ-007 At grant: latch reqLen of the winner into txRemain and rxRemain, each LEN_W+1 bits wide, with 0 mapped to 2^LEN_W.
REQ-008 masterCpol/masterCpha update only on entry to CONFIG, from the owner's cfg bits. CONFIG holds 2 cycles, then exits to XFER once masterTxDataPresent=0 and masterNcs=1.
REQ-009 XFER: txReady = txValid & ~masterTxFull & (txRemain!=0). masterWrite = txReady and masterDataIn = txData, same cycle. Each accept decrements txRemain.
REQ-010 XFER/DRAIN: rxValid = masterRxDataPresent & (rxRemain!=0) & ~readGap. masterRead = rxValid and rxData = masterDataOut. Each read decrements rxRemain and sets readGap for 1 cycle (minimum 2 cycles between reads).
REQ-011 XFER goes to DRAIN when txRemain reaches 0. DRAIN goes to DONE when rxRemain reaches 0.
REQ-012 DONE lasts 1 cycle: done[owner]=1, grant cleared, lastOwner updated, return to IDLE. The earliest re-grant is the cycle after DONE.
REQ-013 nCsOut[i] = masterNcs when grant[i]=1, else 1.
REQ-014 Deasserting req mid-transaction is ignored; the transaction runs to its length. cfg changes mid-transaction are ignored.
REQ-015 Simultaneous write and read in one cycle are permitted.
REQ-016 Outside XFER, txReady=0 and masterWrite=0.

Reset
REQ-017 On rst: state=IDLE, grant=0, done=0, txReady=0, rxValid=0, masterWrite=0, masterRead=0, masterCpol=0, masterCpha=0, nCsOut all 1, counters 0, lastOwner=NUM_REQ-1.
REQ-018 rst mid-transaction aborts immediately with the values in REQ-017. Bytes left in the master RX FIFO are flushed per REQ-005 afterwards.

Structure
REQ-019 A shared package holds the FSM state enum, the NUM_REQ/LEN_W defaults and the CONFIG hold count (2).
REQ-020 One sub-module, spi_rr_arbiter, contains the round-robin priority search: inputs req and lastOwner, output one-hot winner.

Verification
REQ-021 req=0001, len=3, cpol=1, cpha=0, txData 0xA1,0xA2,0xA3 -> three masterWrite pulses, three rxValid, done[0] pulse, masterCpol=1.
REQ-022 req=1111 held over 8 transactions -> grant order 0,1,2,3,0,1,2,3, and each done precedes the next grant.
REQ-023 len=0 -> 256 bytes written and 256 read before done; masterTxFull held high for 10 cycles stalls txReady with no byte lost.
REQ-024 rst asserted in XFER after 2 of 5 bytes -> next cycle all outputs at REQ-017 values; 3 stale RX bytes are flushed before the next grant.
REQ-025 Device 2 cpha=1, device 1 cpha=0, both requesting -> cpha changes only in CONFIG, while masterNcs=1; nCsOut[1] and nCsOut[2] are never both low.

Source files
------------

// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and defaults for the SPI master arbiter and its round-robin search.
package spi_master_arbiter_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_LEN_W   = 8;
    localparam int CFG_HOLD        = 2;

    typedef enum logic [2:0] {
        StIdle,
        StConfig,
        StXfer,
        StDrain,
        StDone
    } arbState_e;

endpackage

// File: rtl/spi_master_arbiter_rr.sv
// Round-robin priority search: the requester closest after lastOwner (wrapping) wins.
module spi_rr_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   lastOwner,
    output logic [NUM_REQ-1:0] winner
);

    logic [IDX_W-1:0] idx;

    // Scan farthest-to-nearest so the nearest requester overwrites any earlier hit.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(lastOwner) + i) % NUM_REQ);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant, per-owner
// CPOL/CPHA, byte streaming to/from the master FIFOs, and per-device chip selects.
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int LEN_W   = DEFAULT_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] reqLen,
    input  logic [NUM_REQ-1:0]       cfgCpol,
    input  logic [NUM_REQ-1:0]       cfgCpha,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    input  logic [7:0]               txData,
    input  logic                     txValid,
    output logic                     txReady,
    output logic [7:0]               rxData,
    output logic                     rxValid,
    output logic [7:0]               masterDataIn,
    output logic                     masterWrite,
    output logic                     masterRead,
    output logic                     masterCpol,
    output logic                     masterCpha,
    input  logic [7:0]               masterDataOut,
    input  logic                     masterTxFull,
    input  logic                     masterTxDataPresent,
    input  logic                     masterRxDataPresent,
    input  logic                     masterNcs,
    output logic [NUM_REQ-1:0]       nCsOut
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = LEN_W + 1;
    localparam int HOLD_W = $clog2(CFG_HOLD + 1);

    arbState_e          state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   lastOwner;
    logic [CNT_W-1:0]   txRemain;
    logic [CNT_W-1:0]   rxRemain;
    logic [HOLD_W-1:0]  cfgCnt;
    logic               readGap;

    logic [NUM_REQ-1:0] winner;
    logic [IDX_W-1:0]   winIdx;
    logic [LEN_W-1:0]   winLen;
    logic [CNT_W-1:0]   winCount;
    logic               flushRead;

    spi_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) uArb (
        .req      (req),
        .lastOwner(lastOwner),
        .winner   (winner)
    );

    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) winIdx = IDX_W'(i);
        end
        winLen   = reqLen[winIdx*LEN_W +: LEN_W];
        winCount = (winLen == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, winLen};
    end

    // Strobes are gated by rst so a reset cycle never moves bytes.
    always_comb begin
        txReady      = !rst && (state == StXfer) && txValid && !masterTxFull
                       && (txRemain != '0);
        rxValid      = !rst && ((state == StXfer) || (state == StDrain))
                       && masterRxDataPresent && (rxRemain != '0) && !readGap;
        flushRead    = !rst && (state == StIdle) && masterRxDataPresent && !readGap;
        masterRead   = rxValid || flushRead;
        masterWrite  = txReady;
        masterDataIn = txData;
        rxData       = masterDataOut;
        for (int i = 0; i < NUM_REQ; i++) begin
            nCsOut[i] = grant[i] ? masterNcs : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            grant      <= '0;
            done       <= '0;
            masterCpol <= 1'b0;
            masterCpha <= 1'b0;
            txRemain   <= '0;
            rxRemain   <= '0;
            cfgCnt     <= '0;
            readGap    <= 1'b0;
            owner      <= '0;
            lastOwner  <= IDX_W'(NUM_REQ - 1);
        end else begin
            done    <= '0;
            readGap <= masterRead;
            if (txReady) txRemain <= txRemain - CNT_W'(1);
            if (rxValid) rxRemain <= rxRemain - CNT_W'(1);
            case (state)
                StIdle: begin
                    if (!masterRxDataPresent && (req != '0)) begin
                        grant      <= winner;
                        owner      <= winIdx;
                        txRemain   <= winCount;
                        rxRemain   <= winCount;
                        masterCpol <= cfgCpol[winIdx];
                        masterCpha <= cfgCpha[winIdx];
                        cfgCnt     <= '0;
                        state      <= StConfig;
                    end
                end
                StConfig: begin
                    if (cfgCnt < HOLD_W'(CFG_HOLD - 1)) begin
                        cfgCnt <= cfgCnt + HOLD_W'(1);
                    end else if (!masterTxDataPresent && masterNcs) begin
                        state <= StXfer;
                    end
                end
                StXfer: begin
                    if (txReady && (txRemain == CNT_W'(1))) state <= StDrain;
                end
                StDrain: begin
                    if ((rxRemain == '0) || (rxValid && (rxRemain == CNT_W'(1)))) begin
                        done      <= grant;
                        grant     <= '0;
                        lastOwner <= owner;
                        state     <= StDone;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a loopback SPI master model.
module tb_spi_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] reqLen;
    logic [3:0]  cfgCpol;
    logic [3:0]  cfgCpha;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [7:0]  masterDataIn;
    logic        masterWrite;
    logic        masterRead;
    logic        masterCpol;
    logic        masterCpha;
    logic [7:0]  masterDataOut = 8'h00;
    logic        masterTxFull;
    logic        masterTxDataPresent;
    logic        masterRxDataPresent = 1'b0;
    logic        masterNcs = 1'b1;
    logic [3:0]  nCsOut;

    always #5 clk = ~clk;

    spi_master_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .reqLen             (reqLen),
        .cfgCpol            (cfgCpol),
        .cfgCpha            (cfgCpha),
        .grant              (grant),
        .done               (done),
        .txData             (txData),
        .txValid            (txValid),
        .txReady            (txReady),
        .rxData             (rxData),
        .rxValid            (rxValid),
        .masterDataIn       (masterDataIn),
        .masterWrite        (masterWrite),
        .masterRead         (masterRead),
        .masterCpol         (masterCpol),
        .masterCpha         (masterCpha),
        .masterDataOut      (masterDataOut),
        .masterTxFull       (masterTxFull),
        .masterTxDataPresent(masterTxDataPresent),
        .masterRxDataPresent(masterRxDataPresent),
        .masterNcs          (masterNcs),
        .nCsOut             (nCsOut)
    );

    // Master model: each written byte returns XOR 0x5A next cycle (when looped back).
    logic [7:0] rxq[$];
    logic [7:0] wrLog[$];
    logic [7:0] rxLog[$];
    logic       loopEn;
    int         injectReq  = 0;
    int         injectDone = 0;

    always @(posedge clk) begin
        if (masterRead && rxq.size() != 0) rxq.delete(0);
        if (masterWrite) begin
            wrLog.push_back(masterDataIn);
            if (loopEn) rxq.push_back(masterDataIn ^ 8'h5A);
        end
        if (rxValid) rxLog.push_back(rxData);
        while (injectDone < injectReq) begin
            rxq.push_back(8'(8'hE0 + injectDone));
            injectDone = injectDone + 1;
        end
        masterRxDataPresent <= (rxq.size() != 0);
        masterDataOut       <= (rxq.size() != 0) ? rxq[0] : 8'h00;
        masterNcs           <= !masterWrite;
    end

    // Protocol monitor.
    logic prevCpha = 1'b0;
    int   cphaChanges = 0;
    int   cphaBad = 0;
    int   ncsBad = 0;
    int   doneGrantBad = 0;

    always @(negedge clk) begin
        if (masterCpha !== prevCpha) begin
            cphaChanges++;
            if (!(masterNcs && grant != 4'b0)) cphaBad++;
        end
        prevCpha = masterCpha;
        if (!nCsOut[1] && !nCsOut[2]) ncsBad++;
        if (done != 4'b0 && grant != 4'b0) doneGrantBad++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendBytes(input int n, input logic [7:0] base, input int stallAt);
        int wt;
        int bad;
        for (int i = 0; i < n; i++) begin
            if (i == stallAt) begin
                bad          = 0;
                masterTxFull = 1'b1;
                txData       = 8'(base + i);
                txValid      = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    #1;
                    if (txReady || masterWrite) bad++;
                    @(negedge clk);
                end
                masterTxFull = 1'b0;
                chk("txFull stall", bad, 0);
            end
            txData  = 8'(base + i);
            txValid = 1'b1;
            #1;
            wt = 0;
            while (!txReady && wt < 500) begin
                @(negedge clk);
                #1;
                wt++;
            end
            if (!txReady) begin
                chk("txReady timeout", txReady, 1);
                break;
            end
            @(negedge clk);
        end
        txValid = 1'b0;
    endtask

    task automatic waitGrant(input string tag, input logic [3:0] exp);
        int n = 0;
        while (grant == 4'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, grant, exp);
    endtask

    task automatic waitDone(input string tag, input logic [3:0] exp);
        int n = 0;
        while (done == 4'b0 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, exp);
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, " grant"}, grant, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " txReady"}, txReady, 0);
        chk({tag, " rxValid"}, rxValid, 0);
        chk({tag, " masterWrite"}, masterWrite, 0);
        chk({tag, " masterRead"}, masterRead, 0);
        chk({tag, " masterCpol"}, masterCpol, 0);
        chk({tag, " masterCpha"}, masterCpha, 0);
        chk({tag, " nCsOut"}, nCsOut, 4'hF);
    endtask

    initial begin
        int w0;
        int r0;
        int bad;
        int reads;
        int n;

        rst = 1'b1; req = '0; reqLen = '0; cfgCpol = '0; cfgCpha = '0;
        txData = '0; txValid = 1'b1; masterTxFull = 1'b0; masterTxDataPresent = 1'b0;
        loopEn = 1'b1;
        repeat (3) @(negedge clk);
        chkResetOutputs("reset");
        rst = 1'b0;
        txValid = 1'b0;

        // Single 3-byte transaction on device 0, CPOL=1.
        reqLen[7:0] = 8'd3;
        cfgCpol = 4'b0001;
        req = 4'b0001;
        waitGrant("t1 grant", 4'b0001);
        chk("t1 cpol", masterCpol, 1);
        chk("t1 cpha", masterCpha, 0);
        chk("t1 nCs config", nCsOut, 4'hF);
        req = 4'b0000;
        w0 = wrLog.size();
        r0 = rxLog.size();
        sendBytes(3, 8'hA1, -1);
        chk("t1 nCs active", nCsOut, 4'hE);
        waitDone("t1 done", 4'b0001);
        chk("t1 grant cleared", grant, 0);
        chk("t1 writes", wrLog.size() - w0, 3);
        chk("t1 reads", rxLog.size() - r0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1 wr byte", wrLog[w0 + i], 8'(8'hA1 + i));
            chk("t1 rx byte", rxLog[r0 + i], 8'(8'hA1 + i) ^ 8'h5A);
        end
        @(negedge clk);
        chk("t1 done width", done, 0);

        // Round robin over 8 one-byte transactions from a fresh reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reqLen = {8'd1, 8'd1, 8'd1, 8'd1};
        cfgCpol = 4'b0000;
        req = 4'hF;
        for (int t = 0; t < 8; t++) begin
            logic [3:0] e;
            e = 4'(1 << (t % 4));
            waitGrant($sformatf("t2 grant %0d", t), e);
            sendBytes(1, 8'(8'h10 + t), -1);
            waitDone($sformatf("t2 done %0d", t), e);
            chk("t2 no grant at done", grant, 0);
            if (t == 7) req = 4'b0000;
        end

        // Length 0 = 256 bytes, with a 10-cycle TX-full stall mid-stream.
        reqLen[15:8] = 8'd0;
        req = 4'b0010;
        waitGrant("t3 grant", 4'b0010);
        req = 4'b0000;
        w0 = wrLog.size();
        r0 = rxLog.size();
        sendBytes(256, 8'h00, 100);
        waitDone("t3 done", 4'b0010);
        chk("t3 writes", wrLog.size() - w0, 256);
        chk("t3 reads", rxLog.size() - r0, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wrLog[w0 + i] !== 8'(i)) bad++;
            if (rxLog[r0 + i] !== (8'(i) ^ 8'h5A)) bad++;
        end
        chk("t3 byte order", bad, 0);

        // Reset mid-transfer, then stale RX bytes must be flushed before re-grant.
        reqLen[23:16] = 8'd5;
        cfgCpol = 4'b0100;
        req = 4'b0100;
        waitGrant("t4 grant", 4'b0100);
        chk("t4 cpol", masterCpol, 1);
        req = 4'b0000;
        loopEn = 1'b0;
        sendBytes(2, 8'h30, -1);
        txValid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chkResetOutputs("t4 abort");
        injectReq = injectReq + 3;
        repeat (3) @(negedge clk);
        chk("t4 stale held", rxq.size(), 3);
        txValid = 1'b0;
        loopEn = 1'b1;
        req = 4'b0100;
        rst = 1'b0;
        reads = 0;
        n = 0;
        while (grant == 4'b0 && n < 50) begin
            #1;
            if (masterRead) reads++;
            @(negedge clk);
            n++;
        end
        chk("t4 flush reads", reads, 3);
        chk("t4 rx empty at grant", masterRxDataPresent, 0);
        chk("t4 regrant", grant, 4'b0100);
        req = 4'b0000;
        sendBytes(5, 8'h40, -1);
        waitDone("t4 done", 4'b0100);

        // CPHA switch between device 1 and device 2.
        cfgCpol = 4'b0000;
        cfgCpha = 4'b0100;
        reqLen[15:8] = 8'd2;
        reqLen[23:16] = 8'd2;
        req = 4'b0110;
        waitGrant("t5 grant dev1", 4'b0010);
        chk("t5 cpha dev1", masterCpha, 0);
        req = 4'b0100;
        sendBytes(2, 8'h50, -1);
        waitDone("t5 done dev1", 4'b0010);
        waitGrant("t5 grant dev2", 4'b0100);
        chk("t5 cpha dev2", masterCpha, 1);
        req = 4'b0000;
        sendBytes(2, 8'h60, -1);
        waitDone("t5 done dev2", 4'b0100);
        chk("t5 cpha changes", cphaChanges, 1);
        chk("t5 cpha outside config", cphaBad, 0);
        chk("nCs overlap", ncsBad, 0);
        chk("done with grant", doneGrantBad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
